// File: rtl/regfile_wb_arbiter.sv
// Two-producer writeback arbiter in front of the register file's single write port.
// Each producer fills its own small FIFO; a round-robin grant drains one head per cycle.
module regfile_wb_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic          wb_hold,
  output logic          wena,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic [CW-1:0] contention_cnt
);

  localparam int EW   = AW + DW;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  // Index 0 is port A, index 1 is port B.
  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    nonempty;
  logic [EW-1:0] in_entry [2];
  logic [EW-1:0] head     [2];

  assign in_valid    = {b_valid, a_valid};
  assign in_entry[0] = {a_addr, a_data};
  assign in_entry[1] = {b_addr, b_data};
  assign a_ready     = in_ready[0];
  assign b_ready     = in_ready[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [EW-1:0]   mem_q [DEPTH];
      logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
      logic [CNTW-1:0] count_q, count_d;

      // Ready depends on occupancy alone, so a full FIFO refuses even while being popped.
      assign in_ready[gi] = (count_q != FULL);
      assign push[gi]     = in_valid[gi] & in_ready[gi];
      assign nonempty[gi] = (count_q != '0);
      assign head[gi]     = mem_q[rd_ptr_q];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop[gi])  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push[gi], pop[gi]})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi]) mem_q[wr_ptr_q] <= in_entry[gi];
      end
    end
  endgenerate

  // last_b_q set means B was granted most recently, so A wins the next tie.
  logic          last_b_q, last_b_d;
  logic          wena_q, wena_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    pop      = 2'b00;
    last_b_d = last_b_q;
    if (!wb_hold) begin
      if (nonempty[0] && (!nonempty[1] || last_b_q)) pop[0] = 1'b1;
      else if (nonempty[1])                          pop[1] = 1'b1;
    end
    if (pop[0]) last_b_d = 1'b0;
    if (pop[1]) last_b_d = 1'b1;
  end

  always_comb begin
    wena_d  = |pop;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pop[1]) begin
      waddr_d = head[1][EW-1:DW];
      wdata_d = head[1][DW-1:0];
    end else if (pop[0]) begin
      waddr_d = head[0][EW-1:DW];
      wdata_d = head[0][DW-1:0];
    end
    cnt_d = cnt_q;
    if (!wb_hold && (&nonempty) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
      wena_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      last_b_q <= last_b_d;
      wena_q   <= wena_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wena           = wena_q;
  assign waddr          = waddr_q;
  assign wdata          = wdata_q;
  assign contention_cnt = cnt_q;
  assign busy           = (|nonempty) | wena_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: a queue-level reference model predicts each writeback and a monitor
// checks every register-file write against it.
module tb_regfile_wb_arbiter;

  localparam int DW = 16, AW = 5, DEPTH = 2, CW = 4, SAT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0, wb_hold = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, wena, busy;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [CW-1:0] contention_cnt;

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wb_hold(wb_hold), .wena(wena), .waddr(waddr), .wdata(wdata),
    .busy(busy), .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  wb_t           qa[$], qb[$], expq[$];
  bit            m_last_b = 1'b1;
  bit            m_wena   = 1'b0;
  int            m_cnt    = 0;
  int            vectors  = 0;
  int            miscompares = 0;
  bit            log_en = 1'b0;
  logic [AW-1:0] wlog[$];
  logic [DW-1:0] rf [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check visible state against the model, drive inputs, advance the model.
  task automatic cycle(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input bit hold);
    bit ga, gb, ra, rb;
    wb_t e;
    @(negedge clk);
    ra = (qa.size() != DEPTH);
    rb = (qb.size() != DEPTH);
    check("a_ready", {31'd0, a_ready}, {31'd0, ra});
    check("b_ready", {31'd0, b_ready}, {31'd0, rb});
    check("contention_cnt", 32'(contention_cnt), 32'(m_cnt));
    check("busy", {31'd0, busy}, {31'd0, (qa.size() != 0) || (qb.size() != 0) || m_wena});
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    wb_hold = hold;
    ga = 1'b0; gb = 1'b0;
    if (!hold) begin
      if (qa.size() != 0 && qb.size() != 0) begin
        if (m_last_b) ga = 1'b1; else gb = 1'b1;
        if (m_cnt < SAT) m_cnt++;
      end else if (qa.size() != 0) ga = 1'b1;
      else if (qb.size() != 0) gb = 1'b1;
    end
    if (ga) begin expq.push_back(qa.pop_front()); m_last_b = 1'b0; end
    if (gb) begin expq.push_back(qb.pop_front()); m_last_b = 1'b1; end
    m_wena = ga || gb;
    if (av && ra) begin e.addr = aa; e.data = ad; qa.push_back(e); end
    if (bv && rb) begin e.addr = ba; e.data = bd; qb.push_back(e); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wena", {31'd0, wena}, 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_cnt", 32'(contention_cnt), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    qa.delete(); qb.delete(); expq.delete();
    m_last_b = 1'b1; m_wena = 1'b0; m_cnt = 0;
    a_valid = 1'b0; b_valid = 1'b0; wb_hold = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: every write on the port must be the next predicted writeback.
  initial begin
    wb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wena) begin
        if (expq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL spurious_write: got waddr %0h wdata %0h, expected no write", waddr, wdata);
        end else begin
          e = expq.pop_front();
          check("waddr", 32'(waddr), 32'(e.addr));
          check("wdata", 32'(wdata), 32'(e.data));
          rf[waddr] = wdata;
          if (log_en) wlog.push_back(waddr);
        end
      end else if (expq.size() != 0) begin
        vectors++; miscompares++;
        $display("FAIL missing_write: got wena 0, expected write to %0h", expq[0].addr);
        expq.delete();
      end
    end
  end

  initial begin
    logic [AW-1:0] exp_order [4];
    exp_order[0] = 5'd1; exp_order[1] = 5'd5; exp_order[2] = 5'd2; exp_order[3] = 5'd6;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single port latency and regfile commit.
    cycle(1, 5'd3, 16'hDEAD, 0, '0, '0, 0);
    idle(4);
    check("rf_r3", 32'(rf[3]), 32'hDEAD);

    // Reset with two entries queued per port; nothing may be written afterwards.
    cycle(1, 5'd7, 16'h1111, 1, 5'd8, 16'h2222, 1);
    cycle(1, 5'd9, 16'h3333, 1, 5'd10, 16'h4444, 1);
    do_reset();
    idle(4);

    // Contention right after reset: A wins the first tie.
    log_en = 1'b1;
    cycle(1, 5'd1, 16'hA001, 1, 5'd5, 16'hB005, 0);
    cycle(1, 5'd2, 16'hA002, 1, 5'd6, 16'hB006, 0);
    idle(5);
    log_en = 1'b0;
    check("order_len", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check("order", 32'(wlog[i]), 32'(exp_order[i]));
    check("contention_3", 32'(contention_cnt), 32'd3);

    // Backpressure on B under hold; third entry waits for a pop.
    cycle(0, '0, '0, 1, 5'd11, 16'hC001, 1);
    cycle(0, '0, '0, 1, 5'd12, 16'hC002, 1);
    cycle(0, '0, '0, 1, 5'd13, 16'hC003, 1);
    cycle(0, '0, '0, 1, 5'd13, 16'hC003, 1);
    cycle(0, '0, '0, 1, 5'd13, 16'hC003, 0);
    cycle(0, '0, '0, 1, 5'd13, 16'hC003, 0);
    idle(5);

    // Hold for five cycles with both ports queued.
    cycle(1, 5'd14, 16'hD001, 1, 5'd15, 16'hE001, 1);
    cycle(1, 5'd16, 16'hD002, 1, 5'd17, 16'hE002, 1);
    for (int i = 0; i < 5; i++) cycle(0, '0, '0, 0, '0, '0, 1);
    idle(6);

    // Saturation: both ports kept busy.
    for (int i = 0; i < 25; i++)
      cycle(1, AW'($urandom), DW'($urandom), 1, AW'($urandom), DW'($urandom), 0);
    check("contention_sat", 32'(contention_cnt), 32'd15);
    idle(6);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle(bit'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            bit'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            ($urandom_range(0, 4) == 0));
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
